mem_arbiter: RTL and testbench

- Shares the single word-serial DRAM port between the instruction cache (block reads only) and the data cache (block write-back and block refill).
- Grants the port to one requester for a whole BLOCK_SIZE-word burst.
- Steers the DRAM handshake and data to and from the granted cache.
- Inserts one release cycle per burst so a requester's lingering request is never granted twice.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single word-serial DRAM port between icache block reads and
// dcache write-back / refill bursts, one whole BLOCK_SIZE-word burst per grant.
module mem_arbiter #(
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_rd_req,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic [DATA_W-1:0] ic_rd_data,
    output logic              ic_rd_val,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              dc_wr_val,
    input  logic              dc_rd_req,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    output logic [DATA_W-1:0] dc_rd_data,
    output logic              dc_rd_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_val,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(BLOCK_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D_WR    = 3'd1,
        D_RD    = 3'd2,
        I_RD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             rr_dc;      // last arbitrated read went to the dcache
    logic             rr_dc_nxt;
    logic             granted_req;

    // State, word counter and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            rr_dc <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            rr_dc <= rr_dc_nxt;
        end
    end

    assign granted_req = ((state == D_WR) && dc_wr_req) ||
                         ((state == D_RD) && dc_rd_req) ||
                         ((state == I_RD) && ic_rd_req);

    // Arbitration and burst progress
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        rr_dc_nxt = rr_dc;
        case (state)
            IDLE: begin
                if (dc_wr_req) begin
                    state_nxt = D_WR;
                end else if (dc_rd_req && (!ic_rd_req || !rr_dc)) begin
                    state_nxt = D_RD;
                    rr_dc_nxt = 1'b1;
                end else if (ic_rd_req) begin
                    state_nxt = I_RD;
                    rr_dc_nxt = 1'b0;
                end
            end
            D_WR, D_RD, I_RD: begin
                // The final word wins over a request that has already dropped
                if (mem_val && (count == LAST_WORD)) begin
                    state_nxt = RELEASE;
                    count_nxt = '0;
                end else if (!granted_req) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (mem_val) begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            RELEASE: state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Port steering decoded from the current state
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        grant      = 2'd0;
        busy       = 1'b0;
        ic_rd_val  = 1'b0;
        dc_rd_val  = 1'b0;
        dc_wr_val  = 1'b0;
        ic_rd_data = mem_rdata;
        dc_rd_data = mem_rdata;
        case (state)
            D_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dc_wr_addr;
                mem_wdata = dc_wr_data;
                grant     = 2'd2;
                busy      = 1'b1;
                dc_wr_val = mem_val;
            end
            D_RD: begin
                mem_req   = 1'b1;
                mem_addr  = dc_rd_addr;
                mem_wdata = dc_wr_data;
                grant     = 2'd2;
                busy      = 1'b1;
                dc_rd_val = mem_val;
            end
            I_RD: begin
                mem_req   = 1'b1;
                mem_addr  = ic_rd_addr;
                mem_wdata = dc_wr_data;
                grant     = 2'd1;
                busy      = 1'b1;
                ic_rd_val = mem_val;
            end
            RELEASE: busy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level model of port ownership.
module tb_mem_arbiter;

    localparam int unsigned BS     = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned VEC_W  = 1 + 1 + ADDR_W + DATA_W + 2 + 1 + 3 + 2 * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_rd_req;
    logic [ADDR_W-1:0] ic_rd_addr;
    logic [DATA_W-1:0] ic_rd_data;
    logic              ic_rd_val;
    logic              dc_wr_req;
    logic [ADDR_W-1:0] dc_wr_addr;
    logic [DATA_W-1:0] dc_wr_data;
    logic              dc_wr_val;
    logic              dc_rd_req;
    logic [ADDR_W-1:0] dc_rd_addr;
    logic [DATA_W-1:0] dc_rd_data;
    logic              dc_rd_val;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_val;
    logic [1:0]        grant;
    logic              busy;

    int vectors   = 0;
    int miscomps  = 0;

    // Model: who owns the port (0 none, 1 icache, 2 dcache write, 3 dcache read)
    int m_owner   = 0;
    int m_words   = 0;
    bit m_release = 1'b0;
    bit m_last_dc = 1'b0;

    mem_arbiter #(.BLOCK_SIZE(BS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_data(ic_rd_data), .ic_rd_val(ic_rd_val),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_val(dc_wr_val),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_data(dc_rd_data), .dc_rd_val(dc_rd_val),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_val(mem_val), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] obs();
        return {mem_req, mem_we, mem_addr, mem_wdata, grant, busy,
                ic_rd_val, dc_rd_val, dc_wr_val, ic_rd_data, dc_rd_data};
    endfunction

    function automatic logic [VEC_W-1:0] expv();
        logic              b;
        logic [ADDR_W-1:0] a;
        logic [1:0]        g;
        b = (m_owner != 0);
        a = (m_owner == 1) ? ic_rd_addr : (m_owner == 2) ? dc_wr_addr :
            (m_owner == 3) ? dc_rd_addr : '0;
        g = (m_owner == 1) ? 2'd1 : (m_owner >= 2) ? 2'd2 : 2'd0;
        return {b, (m_owner == 2), a, (b ? dc_wr_data : DATA_W'(0)), g, (b || m_release),
                (m_owner == 1) && mem_val, (m_owner == 3) && mem_val, (m_owner == 2) && mem_val,
                mem_rdata, mem_rdata};
    endfunction

    task automatic model_step();
        bit owner_req;
        if (reset) begin
            m_owner = 0; m_words = 0; m_release = 1'b0; m_last_dc = 1'b0;
        end else if (m_release) begin
            m_release = 1'b0;
        end else if (m_owner == 0) begin
            if (dc_wr_req) m_owner = 2;
            else if (dc_rd_req && ic_rd_req) begin
                m_owner = m_last_dc ? 1 : 3;
                m_last_dc = !m_last_dc;
            end else if (dc_rd_req) begin
                m_owner = 3; m_last_dc = 1'b1;
            end else if (ic_rd_req) begin
                m_owner = 1; m_last_dc = 1'b0;
            end
        end else begin
            owner_req = (m_owner == 1) ? ic_rd_req : (m_owner == 2) ? dc_wr_req : dc_rd_req;
            if (mem_val && m_words == BS - 1) begin
                m_owner = 0; m_words = 0; m_release = 1'b1;
            end else if (!owner_req) begin
                m_owner = 0; m_words = 0;
            end else if (mem_val) begin
                m_words++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ic_rd_req = 1'b0; dc_wr_req = 1'b0; dc_rd_req = 1'b0; mem_val = 1'b0;
        ic_rd_addr = '0; dc_wr_addr = '0; dc_rd_addr = '0; dc_wr_data = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        mem_val = 1'b1; ic_rd_req = 1'b1; dc_rd_req = 1'b1;
        tick();
        tick();
        #1;
        vectors++;
        if (obs() !== expv()) begin
            miscomps++;
            $display("FAIL reset_model obs=%h exp=%h", obs(), expv());
        end
        vectors++;
        if ({mem_req, mem_we, mem_addr, grant, busy, ic_rd_val, dc_rd_val, dc_wr_val} !== '0) begin
            miscomps++;
            $display("FAIL reset_outputs req=%b we=%b addr=%h grant=%0d busy=%b vals=%b%b%b required all 0",
                     mem_req, mem_we, mem_addr, grant, busy, ic_rd_val, dc_rd_val, dc_wr_val);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    // Single icache read, including a request that lingers into the release cycle
    task automatic test_icache_read();
        int vals = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            ic_rd_req  = (c <= 9);
            ic_rd_addr = 32'h100;
            mem_val    = (c >= 1 && c <= 8);
            mem_rdata  = DATA_W'(c);
            #1;
            vectors++;
            if (obs() !== expv()) begin
                miscomps++;
                $display("FAIL icache_read cyc=%0d obs=%h exp=%h", c, obs(), expv());
            end
            if (ic_rd_val) vals++;
            if (c == 1) begin
                vectors++;
                if ({mem_req, mem_we, mem_addr, grant, dc_rd_val} !== {1'b1, 1'b0, 32'h100, 2'd1, 1'b0}) begin
                    miscomps++;
                    $display("FAIL icache_first_word req=%b we=%b addr=%h grant=%0d required 1 0 100 1",
                             mem_req, mem_we, mem_addr, grant);
                end
            end
            if (c >= 9) begin
                vectors++;
                if ({mem_req, grant, busy} !== {1'b0, 2'd0, (c == 9)}) begin
                    miscomps++;
                    $display("FAIL icache_release cyc=%0d req=%b grant=%0d busy=%b required 0 0 %0d",
                             c, mem_req, grant, busy, (c == 9));
                end
            end
            tick();
        end
        vectors++;
        if (vals !== 8) begin
            miscomps++;
            $display("FAIL icache_val_count got=%0d required=8", vals);
        end
    endtask

    // Write-back, then refill requested in the release cycle while the icache waits
    task automatic test_wb_refill();
        int wr_vals = 0;
        int rd_vals = 0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            dc_wr_req  = (c <= 8);
            dc_rd_req  = (c >= 9 && c <= 19);
            ic_rd_req  = (c >= 9);
            dc_wr_addr = 32'h2000;
            dc_rd_addr = 32'h3000;
            ic_rd_addr = 32'h4000;
            dc_wr_data = 32'hA000_0000 + DATA_W'(c);
            mem_val    = (c >= 1 && c <= 8) || (c >= 11 && c <= 18);
            mem_rdata  = $urandom;
            #1;
            vectors++;
            if (obs() !== expv()) begin
                miscomps++;
                $display("FAIL wb_refill cyc=%0d obs=%h exp=%h", c, obs(), expv());
            end
            if (dc_wr_val) wr_vals++;
            if (dc_rd_val) rd_vals++;
            if (c == 3) begin
                vectors++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h2000, 32'hA000_0003}) begin
                    miscomps++;
                    $display("FAIL wb_write we=%b addr=%h wdata=%h required 1 2000 a0000003",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 11) begin
                vectors++;
                if ({mem_req, mem_we, mem_addr, grant} !== {1'b1, 1'b0, 32'h3000, 2'd2}) begin
                    miscomps++;
                    $display("FAIL wb_refill_grant req=%b we=%b addr=%h grant=%0d required 1 0 3000 2",
                             mem_req, mem_we, mem_addr, grant);
                end
            end
            tick();
        end
        vectors++;
        if (wr_vals !== 8 || rd_vals !== 8) begin
            miscomps++;
            $display("FAIL wb_refill_counts wr=%0d rd=%0d required 8 8", wr_vals, rd_vals);
        end
        idle_inputs();
    endtask

    // Both readers held high: grants alternate starting with the dcache
    task automatic test_round_robin();
        int  starts[$];
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            ic_rd_req = 1'b1; dc_rd_req = 1'b1;
            ic_rd_addr = 32'h500; dc_rd_addr = 32'h600;
            mem_val = 1'b1; mem_rdata = $urandom;
            #1;
            vectors++;
            if (obs() !== expv()) begin
                miscomps++;
                $display("FAIL round_robin cyc=%0d obs=%h exp=%h", c, obs(), expv());
            end
            if (mem_req && !prev) starts.push_back(int'(grant));
            prev = mem_req;
            tick();
        end
        vectors++;
        if (starts.size() < 4) begin
            miscomps++;
            $display("FAIL rr_burst_count got=%0d required>=4", starts.size());
        end
        foreach (starts[k]) begin
            vectors++;
            if (starts[k] !== ((k % 2 == 0) ? 2 : 1)) begin
                miscomps++;
                $display("FAIL rr_order burst=%0d grant=%0d required=%0d", k, starts[k], (k % 2 == 0) ? 2 : 1);
            end
        end
        idle_inputs();
    endtask

    // Write-back beats both reads and leaves the round-robin pointer alone
    task automatic test_write_priority();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            dc_wr_req = (c <= 8); dc_rd_req = 1'b1; ic_rd_req = 1'b1;
            dc_wr_addr = 32'h700; dc_rd_addr = 32'h800; ic_rd_addr = 32'h900;
            mem_val = (c >= 1 && c <= 8); mem_rdata = $urandom;
            #1;
            vectors++;
            if (obs() !== expv()) begin
                miscomps++;
                $display("FAIL write_priority cyc=%0d obs=%h exp=%h", c, obs(), expv());
            end
            if (c == 1 || c == 11) begin
                vectors++;
                if ({mem_we, mem_addr} !== ((c == 1) ? {1'b1, 32'h700} : {1'b0, 32'h800})) begin
                    miscomps++;
                    $display("FAIL write_priority_grant cyc=%0d we=%b addr=%h", c, mem_we, mem_addr);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    // Reset three words into a burst, then a full burst, then a stray mem_val
    task automatic test_abort();
        int vals = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            reset = (c == 4);
            ic_rd_req = (c <= 4) || (c >= 6 && c <= 16);
            ic_rd_addr = 32'hC00;
            mem_val = (c >= 1 && c <= 3) || (c >= 8) ;
            mem_rdata = $urandom;
            #1;
            vectors++;
            if (obs() !== expv()) begin
                miscomps++;
                $display("FAIL abort cyc=%0d obs=%h exp=%h", c, obs(), expv());
            end
            if (c == 5) begin
                vectors++;
                if ({mem_req, busy, grant, ic_rd_val} !== '0) begin
                    miscomps++;
                    $display("FAIL abort_after_reset req=%b busy=%b grant=%0d val=%b required 0",
                             mem_req, busy, grant, ic_rd_val);
                end
            end
            if (c >= 6 && ic_rd_val) vals++;
            if (c >= 18) begin
                vectors++;
                if ({ic_rd_val, dc_rd_val, dc_wr_val} !== 3'b000) begin
                    miscomps++;
                    $display("FAIL stray_val cyc=%0d vals=%b%b%b required 000", c, ic_rd_val, dc_rd_val, dc_wr_val);
                end
            end
            tick();
        end
        vectors++;
        if (vals !== 8) begin
            miscomps++;
            $display("FAIL abort_rerun_vals got=%0d required=8", vals);
        end
        idle_inputs();
    endtask

    // Randomized traffic with sticky requests, drops mid-burst and rare resets
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) ic_rd_req = !ic_rd_req;
            if ($urandom_range(0, 11) == 0) dc_wr_req = !dc_wr_req;
            if ($urandom_range(0, 7) == 0) dc_rd_req = !dc_rd_req;
            if ($urandom_range(0, 15) == 0) ic_rd_addr = $urandom;
            if ($urandom_range(0, 15) == 0) dc_wr_addr = $urandom;
            if ($urandom_range(0, 15) == 0) dc_rd_addr = $urandom;
            dc_wr_data = $urandom;
            mem_rdata  = $urandom;
            mem_val    = ($urandom_range(0, 9) < 7);
            #1;
            vectors++;
            if (obs() !== expv()) begin
                miscomps++;
                $display("FAIL random cyc=%0d obs=%h exp=%h", c, obs(), expv());
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_wb_refill();
        test_round_robin();
        test_write_priority();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end

endmodule
